sample_sequencer: RTL
=====================

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 Parameter N, default 10: ADC/DAC sample width in bits.
REQ-002 Parameter DIV, default 1041: clk cycles per audio sample (50 MHz / 48 kHz, rounded down).
REQ-003 Parameter FILT_WAIT, default 4: clk cycles allowed for the combinational IIR output to settle.
REQ-004 Parameter POT_EVERY, default 64: audio samples per pot conversion; power of two.
REQ-005 clk  in  1  system clock.
REQ-006 reset_n  in  1  reset; asynchronous, active-low.
REQ-007 filt_type  in  1  0=LPF, 1=HPF; asynchronous switch input.
REQ-008 adc_start  out  1  one-cycle request to the shared MCP3008 SPI controller.
REQ-009 adc_chan  out  3  channel for the request: 0=audio, 1=LPF pot, 2=HPF pot.
REQ-010 adc_done  in  1  one-cycle pulse; adc_data is valid in the same cycle.
REQ-011 adc_data  in  N  conversion result.
REQ-012 x0, x1, y1  out  N each  IIR operands x[n], x[n-1] and y[n-1].
REQ-013 iir_out  in  N  IIR result, combinational from x0/x1/y1.
REQ-014 pwm_duty  out  N  duty word to the PWM DAC.
REQ-015 pwm_load  out  1  one-cycle strobe; pwm_duty is new in this cycle.
REQ-016 pot_val  out  N  last pot conversion result.
REQ-017 pot_valid  out  1  one-cycle strobe when pot_val updates.
REQ-018 overrun  out  1  sticky flag: a sample tick was missed.

Function
REQ-019 The tick counter SHALL count 0..DIV-1 continuously and SHALL assert tick for one cycle at DIV-1.
REQ-020 The FSM SHALL have the states IDLE, REQ_AUD, WAIT_AUD, FILTER, UPDATE, REQ_POT and WAIT_POT.
REQ-021 IDLE SHALL move to REQ_AUD on tick.
REQ-022 REQ_AUD SHALL assert adc_start for exactly one cycle with adc_chan=0, then move to WAIT_AUD.
REQ-023 WAIT_AUD SHALL wait for adc_done, then set x1<=x0 and x0<=adc_data and move to FILTER.
REQ-024 FILTER SHALL wait exactly FILT_WAIT cycles, then move to UPDATE.
REQ-025 UPDATE SHALL set y1<=iir_out and pwm_duty<=iir_out and pulse pwm_load.
REQ-026 UPDATE SHALL increment the pot sample counter modulo POT_EVERY.
REQ-027 UPDATE SHALL move to REQ_POT when the pre-increment pot count is 0; otherwise it SHALL move to IDLE.
REQ-028 REQ_POT SHALL pulse adc_start with adc_chan=1 when filt_sync=0, or adc_chan=2 when filt_sync=1, then move to WAIT_POT.
REQ-029 WAIT_POT SHALL capture pot_val<=adc_data on adc_done, pulse pot_valid, and move to IDLE.
REQ-030 adc_chan SHALL hold its value from the adc_start cycle until the matching adc_done.
REQ-031 adc_done outside WAIT_AUD and WAIT_POT SHALL be ignored.
REQ-032 A tick seen outside IDLE SHALL be dropped and SHALL set overrun; overrun SHALL clear only on reset.
REQ-033 A tick arriving in the same cycle as the return to IDLE SHALL be dropped and SHALL set overrun.
REQ-034 filt_type SHALL pass through a 2-flop synchronizer to give filt_sync.
REQ-035 A change of filt_sync SHALL set x1 and y1 to MID = 2^(N-1) in the next WAIT_AUD capture, instead of the shifted values.
REQ-036 Latency from tick to pwm_load SHALL be 2 + ADC latency + FILT_WAIT + 1 cycles.

Reset
REQ-037 While reset_n=0, the FSM SHALL be IDLE and both counters SHALL be 0.
REQ-038 While reset_n=0, x0, x1, y1 and pwm_duty SHALL be MID, and pot_val SHALL be 0.
REQ-039 While reset_n=0, adc_start, pwm_load, pot_valid, overrun and adc_chan SHALL be 0.
REQ-040 Reset asserted mid-conversion SHALL abandon the conversion; a late adc_done after reset SHALL be ignored.

Structure
REQ-041 The shared package SHALL hold the state enum, the channel constants CH_AUDIO, CH_LPF and CH_HPF, and MID.
REQ-042 The tick divider SHALL be a sub-module, sample_tick_gen, with parameter DIV.

Verification
REQ-043 Scenario: ADC model answers 20 cycles after adc_start with data 700, iir_out = x0 -> pwm_load 2+20+4+1 cycles after tick, with pwm_duty=700.
REQ-044 Scenario: 65 consecutive samples -> channel-1 pot requests after samples 1 and 65 only; pot_valid twice.
REQ-045 Scenario: ADC latency 1100 cycles -> overrun=1, the tick is dropped, and exactly one pwm_load occurs per completed sample.
REQ-046 Scenario: filt_type toggled 0->1 -> next capture gives x1=y1=512; the next pot request uses adc_chan=2.
REQ-047 Scenario: reset_n pulsed low in WAIT_AUD -> outputs are MID or 0, and an adc_done one cycle after release leaves x0=512.
REQ-048 Scenario: a spurious adc_done in IDLE -> x0, pot_val and the state are unchanged.

Source files
------------

// File: rtl/sample_sequencer_pkg.sv
// Shared types and constants for the audio sample sequencer: FSM states,
// MCP3008 channel numbers and the mid-scale operand value.
package sample_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ_AUD  = 3'd1,
    S_WAIT_AUD = 3'd2,
    S_FILTER   = 3'd3,
    S_UPDATE   = 3'd4,
    S_REQ_POT  = 3'd5,
    S_WAIT_POT = 3'd6
  } state_t;

  localparam logic [2:0] CH_AUDIO = 3'd0;
  localparam logic [2:0] CH_LPF   = 3'd1;
  localparam logic [2:0] CH_HPF   = 3'd2;

  localparam int unsigned N_DEFAULT = 10;

  // Mid-scale code 2^(n-1) for an n-bit sample.
  function automatic int unsigned mid_of(input int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

  localparam int unsigned MID = mid_of(N_DEFAULT);

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: counts 0..DIV-1 and flags the last count.
module sample_tick_gen #(
  parameter int DIV = 1041
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets a default before any condition, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sample_sequencer.sv
// Sequences one audio conversion, IIR settle and PWM update per sample tick,
// plus a pot conversion every POT_EVERY samples, over a shared MCP3008 port.
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter int N         = 10,
  parameter int DIV       = 1041,
  parameter int FILT_WAIT = 4,
  parameter int POT_EVERY = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         filt_type_i,
  output logic         adc_start_o,
  output logic [2:0]   adc_chan_o,
  input  logic         adc_done_i,
  input  logic [N-1:0] adc_data_i,
  output logic [N-1:0] x0_o,
  output logic [N-1:0] x1_o,
  output logic [N-1:0] y1_o,
  input  logic [N-1:0] iir_out_i,
  output logic [N-1:0] pwm_duty_o,
  output logic         pwm_load_o,
  output logic [N-1:0] pot_val_o,
  output logic         pot_valid_o,
  output logic         overrun_o
);

  localparam int PW = (POT_EVERY > 1) ? $clog2(POT_EVERY) : 1;
  localparam int FW = (FILT_WAIT > 1) ? $clog2(FILT_WAIT) : 1;
  localparam logic [N-1:0]  MID_N     = N'(mid_of(N));
  localparam logic [PW-1:0] POT_LAST  = PW'(POT_EVERY - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_WAIT - 1);

  logic tick;

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_o  (tick)
  );

  state_t        state_q;
  logic [PW-1:0] pot_cnt_q, pot_cnt_d;
  logic [FW-1:0] filt_cnt_q;
  logic          filt_meta_q, filt_sync_q, filt_seen_q;
  logic          adc_start_q, pwm_load_q, pot_valid_q, overrun_q;
  logic [2:0]    adc_chan_q;
  logic [N-1:0]  x0_q, x1_q, y1_q, pwm_duty_q, pot_val_q;

  assign pot_cnt_d = (pot_cnt_q == POT_LAST) ? '0 : pot_cnt_q + PW'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every register reads pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pot_cnt_q   <= '0;
      filt_cnt_q  <= '0;
      filt_meta_q <= 1'b0;
      filt_sync_q <= 1'b0;
      filt_seen_q <= 1'b0;
      adc_start_q <= 1'b0;
      adc_chan_q  <= CH_AUDIO;
      pwm_load_q  <= 1'b0;
      pot_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      x0_q        <= MID_N;
      x1_q        <= MID_N;
      y1_q        <= MID_N;
      pwm_duty_q  <= MID_N;
      pot_val_q   <= '0;
    end else begin
      filt_meta_q <= filt_type_i;
      filt_sync_q <= filt_meta_q;
      adc_start_q <= 1'b0;
      pwm_load_q  <= 1'b0;
      pot_valid_q <= 1'b0;

      // Any tick not taken from IDLE, including one on the cycle we head back, is lost.
      if (tick && state_q != S_IDLE) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q     <= S_REQ_AUD;
            adc_start_q <= 1'b1;
            adc_chan_q  <= CH_AUDIO;
          end
        end
        S_REQ_AUD: state_q <= S_WAIT_AUD;
        S_WAIT_AUD: begin
          if (adc_done_i) begin
            x0_q       <= adc_data_i;
            filt_cnt_q <= '0;
            state_q    <= S_FILTER;
            if (filt_sync_q != filt_seen_q) begin
              // Filter type changed: restart the recursion from mid-scale.
              x1_q        <= MID_N;
              y1_q        <= MID_N;
              filt_seen_q <= filt_sync_q;
            end else begin
              x1_q <= x0_q;
            end
          end
        end
        S_FILTER: begin
          if (filt_cnt_q == FILT_LAST) state_q    <= S_UPDATE;
          else                         filt_cnt_q <= filt_cnt_q + FW'(1);
        end
        S_UPDATE: begin
          y1_q       <= iir_out_i;
          pwm_duty_q <= iir_out_i;
          pwm_load_q <= 1'b1;
          pot_cnt_q  <= pot_cnt_d;
          if (pot_cnt_q == '0) begin
            state_q     <= S_REQ_POT;
            adc_start_q <= 1'b1;
            adc_chan_q  <= filt_sync_q ? CH_HPF : CH_LPF;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_REQ_POT: state_q <= S_WAIT_POT;
        S_WAIT_POT: begin
          if (adc_done_i) begin
            pot_val_q   <= adc_data_i;
            pot_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_start_o = adc_start_q;
  assign adc_chan_o  = adc_chan_q;
  assign x0_o        = x0_q;
  assign x1_o        = x1_q;
  assign y1_o        = y1_q;
  assign pwm_duty_o  = pwm_duty_q;
  assign pwm_load_o  = pwm_load_q;
  assign pot_val_o   = pot_val_q;
  assign pot_valid_o = pot_valid_q;
  assign overrun_o   = overrun_q;

endmodule
